// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, valid/ready
// handshake with a global stall. Supports logical/arithmetic shift and rotate in
// both directions plus pass-through, with an accumulated overflow flag.
module barrel_shifter_pipe #(
  parameter  int unsigned bit_size = 8,
  localparam int unsigned NSTG     = $clog2(bit_size)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [bit_size-1:0] in_data,
  input  logic [NSTG-1:0]     in_num_shift,
  input  logic                in_direction,
  input  logic [1:0]          in_sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [bit_size-1:0] out_data,
  output logic                out_overflow
);

  localparam logic [1:0] SEL_LOGIC  = 2'd0;
  localparam logic [1:0] SEL_ARITH  = 2'd1;
  localparam logic [1:0] SEL_ROTATE = 2'd2;

  // One stage of shifting by s; returns {overflow, data}.
  function automatic logic [bit_size:0] shift_stage(
    input logic [bit_size-1:0] d,
    input logic                do_shift,
    input int unsigned         s,
    input logic                dir,
    input logic [1:0]          sel
  );
    logic [bit_size-1:0] r;
    logic [bit_size-1:0] top;
    logic [bit_size-1:0] ones;
    logic [bit_size-1:0] mask;
    logic                ov;
    r    = d;
    ov   = 1'b0;
    ones = '1;
    top  = '0;
    // Mask covering the s+1 most significant bits once shifted down to the LSBs.
    mask = ones >> (bit_size - 1 - s);
    if (do_shift) begin
      unique case (sel)
        SEL_LOGIC: begin
          if (dir) begin
            r = d >> s;
          end else begin
            r  = d << s;
            ov = (d >> (bit_size - s)) != '0;
          end
        end
        SEL_ARITH: begin
          if (dir) begin
            r = bit_size'($signed(d) >>> s);
          end else begin
            r   = d << s;
            top = d >> (bit_size - 1 - s);
            ov  = (top != '0) && (top != mask);
          end
        end
        SEL_ROTATE: begin
          if (dir) begin
            r = (d >> s) | (d << (bit_size - s));
          end else begin
            r = (d << s) | (d >> (bit_size - s));
          end
        end
        default: r = d;
      endcase
    end
    return {ov, r};
  endfunction

  // Stage registers
  logic [bit_size-1:0] data_q [NSTG];
  logic [bit_size-1:0] data_d [NSTG];
  logic [NSTG-1:0]     sh_q   [NSTG];
  logic [NSTG-1:0]     sh_d   [NSTG];
  logic                dir_q  [NSTG];
  logic                dir_d  [NSTG];
  logic [1:0]          sel_q  [NSTG];
  logic [1:0]          sel_d  [NSTG];
  logic [NSTG-1:0]     vld_q;
  logic [NSTG-1:0]     vld_d;
  logic [NSTG-1:0]     ov_q;
  logic [NSTG-1:0]     ov_d;

  // Per-stage inputs: stage 0 from the port, stage k from stage k-1
  logic [bit_size-1:0] src_data [NSTG];
  logic [NSTG-1:0]     src_sh   [NSTG];
  logic                src_dir  [NSTG];
  logic [1:0]          src_sel  [NSTG];
  logic [NSTG-1:0]     src_vld;
  logic [NSTG-1:0]     src_ov;
  logic [bit_size:0]   res;

  logic en;

  // Whole pipe advances unless the output holds an unconsumed result.
  assign en        = !vld_q[NSTG-1] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[NSTG-1];
  assign out_data  = data_q[NSTG-1];
  assign out_overflow = ov_q[NSTG-1];

  // Route stage inputs and compute each stage's next state.
  always_comb begin
    res         = '0;
    src_data[0] = in_data;
    src_sh[0]   = in_num_shift;
    src_dir[0]  = in_direction;
    src_sel[0]  = in_sel;
    src_vld[0]  = in_valid;
    src_ov[0]   = 1'b0;
    for (int k = 1; k < NSTG; k++) begin
      src_data[k] = data_q[k-1];
      src_sh[k]   = sh_q[k-1];
      src_dir[k]  = dir_q[k-1];
      src_sel[k]  = sel_q[k-1];
      src_vld[k]  = vld_q[k-1];
      src_ov[k]   = ov_q[k-1];
    end
    for (int k = 0; k < NSTG; k++) begin
      res       = shift_stage(src_data[k], src_sh[k][0], 32'(1) << k, src_dir[k], src_sel[k]);
      data_d[k] = res[bit_size-1:0];
      ov_d[k]   = src_ov[k] | res[bit_size];
      vld_d[k]  = src_vld[k];
      sh_d[k]   = src_sh[k] >> 1;
      dir_d[k]  = src_dir[k];
      sel_d[k]  = src_sel[k];
    end
  end

  // Stage registers: cleared by reset, all stages move together when enabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= '{default: '0};
      sh_q   <= '{default: '0};
      dir_q  <= '{default: 1'b0};
      sel_q  <= '{default: '0};
      vld_q  <= '0;
      ov_q   <= '0;
    end else if (en) begin
      data_q <= data_d;
      sh_q   <= sh_d;
      dir_q  <= dir_d;
      sel_q  <= sel_d;
      vld_q  <= vld_d;
      ov_q   <= ov_d;
    end
  end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed and random bench for barrel_shifter_pipe at bit_size = 8.
module tb_barrel_shifter_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned NS = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [NS-1:0] in_num_shift = '0;
  logic          in_direction = 1'b0;
  logic [1:0]    in_sel = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_overflow;

  barrel_shifter_pipe #(.bit_size(W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_num_shift (in_num_shift),
    .in_direction (in_direction),
    .in_sel       (in_sel),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  data;
    logic [NS-1:0] sh;
    logic          dir;
    logic [1:0]    sel;
    logic [W-1:0]  exp_data;
    logic          exp_ov;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] d;
    logic         ov;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[15];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   out_idx  = 0;
  logic done     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Whole-operation reference model: returns {overflow, data}.
  function automatic logic [W:0] model(input logic [W-1:0] d, input logic [NS-1:0] n,
                                       input logic dir, input logic [1:0] sel);
    int           nn;
    logic [W-1:0] r;
    logic [W-1:0] top;
    logic         ov;
    nn = int'(n);
    r  = d;
    ov = 1'b0;
    if (sel != 2'd3 && nn != 0) begin
      case (sel)
        2'd0: begin
          if (dir) r = d >> nn;
          else begin
            r  = d << nn;
            ov = (d >> (W - nn)) != '0;
          end
        end
        2'd1: begin
          if (dir) r = W'($signed(d) >>> nn);
          else begin
            r   = d << nn;
            top = d >> (W - 1 - nn);
            ov  = !(top == '0 || top == W'((1 << (nn + 1)) - 1));
          end
        end
        default: begin
          if (dir) r = (d >> nn) | (d << (W - nn));
          else     r = (d << nn) | (d >> (W - nn));
        end
      endcase
    end
    return {ov, r};
  endfunction

  // Present one op and wait (bounded) for acceptance; queue its expected result.
  task automatic send(input logic [W-1:0] d, input logic [NS-1:0] n, input logic dir,
                      input logic [1:0] sel, input logic [W-1:0] ed, input logic eov);
    int waited = 0;
    in_valid     = 1'b1;
    in_data      = d;
    in_num_shift = n;
    in_direction = dir;
    in_sel       = sel;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 200 cycles");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    exp_q.push_back({ed, eov});
    #1;
  endtask

  task automatic send_vec(input int i);
    send(vecs[i].data, vecs[i].sh, vecs[i].dir, vecs[i].sel, vecs[i].exp_data, vecs[i].exp_ov);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      step();
      t++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard plus stall checks, sampled on the falling edge.
  task automatic monitor();
    logic         stalled_prev = 1'b0;
    logic [W-1:0] held_d = '0;
    logic         held_ov = 1'b0;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stalled_prev = 1'b0;
        continue;
      end
      if (out_valid && !out_ready) begin
        chk("in_ready_stall", 32'(in_ready), 32'd0);
        if (stalled_prev) begin
          chk("hold_data", 32'(out_data), 32'(held_d));
          chk("hold_ov", 32'(out_overflow), 32'(held_ov));
        end
        stalled_prev = 1'b1;
        held_d  = out_data;
        held_ov = out_overflow;
      end else begin
        stalled_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("out_data#%0d", out_idx), 32'(out_data), 32'(e.d));
          chk($sformatf("out_ov#%0d", out_idx), 32'(out_overflow), 32'(e.ov));
          out_idx++;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0]  rd;
    logic [NS-1:0] rn;
    logic          rdir;
    logic [1:0]    rsel;
    logic [W:0]    m;

    //          data   sh    dir   sel    exp    ov
    vecs[0]  = '{8'h96, 3'd3, 1'b0, 2'd0, 8'hB0, 1'b1};
    vecs[1]  = '{8'h96, 3'd3, 1'b1, 2'd1, 8'hF2, 1'b0};
    vecs[2]  = '{8'h96, 3'd3, 1'b1, 2'd2, 8'hD2, 1'b0};
    vecs[3]  = '{8'h96, 3'd3, 1'b0, 2'd2, 8'hB4, 1'b0};
    vecs[4]  = '{8'h96, 3'd3, 1'b1, 2'd0, 8'h12, 1'b0};
    vecs[5]  = '{8'h96, 3'd3, 1'b0, 2'd3, 8'h96, 1'b0};
    vecs[6]  = '{8'h96, 3'd1, 1'b0, 2'd1, 8'h2C, 1'b1};
    vecs[7]  = '{8'h0F, 3'd3, 1'b0, 2'd1, 8'h78, 1'b0};
    vecs[8]  = '{8'h0F, 3'd4, 1'b0, 2'd1, 8'hF0, 1'b1};
    vecs[9]  = '{8'h96, 3'd3, 1'b1, 2'd3, 8'h96, 1'b0};
    vecs[10] = '{8'hA5, 3'd0, 1'b1, 2'd1, 8'hA5, 1'b0};
    vecs[11] = '{8'h80, 3'd7, 1'b1, 2'd1, 8'hFF, 1'b0};
    vecs[12] = '{8'h01, 3'd7, 1'b0, 2'd2, 8'h80, 1'b0};
    vecs[13] = '{8'hFF, 3'd7, 1'b0, 2'd0, 8'h80, 1'b1};
    vecs[14] = '{8'h40, 3'd1, 1'b0, 2'd1, 8'h80, 1'b1};

    fork
      monitor();
    join_none

    // Reset and post-reset state
    #2 rstn = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ov", 32'(out_overflow), 32'd0);
    repeat (3) step();
    rstn = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single op latency: result visible after the third edge counting acceptance
    out_ready = 1'b1;
    send_vec(0);
    in_valid = 1'b0;
    chk("lat_edge1_valid", 32'(out_valid), 32'd0);
    step();
    chk("lat_edge2_valid", 32'(out_valid), 32'd0);
    step();
    chk("lat_edge3_valid", 32'(out_valid), 32'd1);
    chk("lat_data", 32'(out_data), 32'hB0);
    chk("lat_ov", 32'(out_overflow), 32'd1);
    drain();

    // Whole vector table back-to-back
    for (int i = 0; i < 15; i++) send_vec(i);
    in_valid = 1'b0;
    drain();

    // Backpressure mid-stream
    fork
      begin
        for (int i = 1; i <= 5; i++) send_vec(i);
        in_valid = 1'b0;
      end
      begin
        repeat (2) step();
        out_ready = 1'b0;
        repeat (4) step();
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three ops in flight
    send_vec(1);
    send_vec(2);
    send_vec(3);
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rstn = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data", 32'(out_data), 32'd0);
    exp_q.delete();
    repeat (2) step();
    rstn = 1'b1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("no_stale_valid", 32'(out_valid), 32'd0);
    end
    send(8'h5A, 3'd0, 1'b1, 2'd1, 8'h5A, 1'b0);
    send(8'hC3, 3'd0, 1'b0, 2'd0, 8'hC3, 1'b0);
    in_valid = 1'b0;
    drain();

    // Random regression against the model
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            step();
          end
          rd   = W'($urandom);
          rn   = NS'($urandom);
          rdir = 1'($urandom);
          rsel = 2'($urandom);
          m    = model(rd, rn, rdir, rsel);
          send(rd, rn, rdir, rsel, m[W-1:0], m[W]);
        end
        in_valid = 1'b0;
        drain();
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          step();
        end
        out_ready = 1'b1;
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
